serial_pattern_generator: RTL and testbench
===========================================

// Module: serial_pattern_generator
// PURPOSE
//  Serializing transmitter feeding the sequence-detector family (e.g. the 0110
//  overlapping detector). Accepts a parallel pattern, length and repeat count over
//  a valid/ready load port, then shifts the pattern out MSB-first, one bit per
//  enabled clock, on data_out/data_valid. It drives the detectors' clk/en/data_in
//  directly in system tests and on-board demos.
// PARAMETERS
//  WIDTH       8     max pattern length in bits (>=2)
//  REP_W       4     width of repeat-count field
//  IDLE_LEVEL  1'b0  data_out level while not transmitting
// PORTS
//  clk           in   1        system clock, all logic on posedge
//  reset         in   1        synchronous, active-high reset
//  en            in   1        clock enable; 0 freezes transmission
//  load_valid    in   1        load request
//  load_ready    out  1        block can accept a load (IDLE)
//  load_pattern  in   WIDTH    pattern; active bits are [load_len-1:0]
//  load_len      in   $clog2(WIDTH+1)  bits per pass; 0 or >WIDTH => WIDTH
//  load_repeat   in   REP_W    extra passes (0 => one pass, N => N+1 passes)
//  data_out      out  1        serial bit (registered), connects to detector data_in
//  data_valid    out  1        data_out carries a new bit this cycle
//  busy          out  1        transmission in progress (LOAD accepted, not done)
//  done          out  1        one-cycle pulse after last bit of last pass
// BEHAVIOUR
//  Reset: state=IDLE, data_out=IDLE_LEVEL, data_valid=0, busy=0, done=0,
//   load_ready=1, internal counters 0. Reset mid-transmission aborts at that edge;
//   no done pulse, partially sent pattern is lost.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: load_ready=1, busy=0. load_valid&load_ready at edge N captures pattern,
//   effective len, repeat; bit_idx=len-1, pass_cnt=repeat; go SHIFT, busy=1 from N+1.
//  SHIFT: load_ready=0; load_valid ignored (no capture, no error).
//   Each edge with en=1: data_out<=pattern[bit_idx], data_valid<=1, bit_idx--.
//   First bit visible in cycle after capture if en=1 (latency 1).
//   en=0: data_valid<=0, data_out holds, bit_idx/pass_cnt frozen; resume unchanged.
//   After bit_idx==0 sent: if pass_cnt!=0 -> pass_cnt--, bit_idx=len-1, next bit
//   is pattern MSB on the very next enabled cycle (no gap between passes);
//   else -> DONE.
//  DONE: one cycle; done=1, data_valid=0, data_out=IDLE_LEVEL, busy=0,
//   load_ready=1 (a load in this cycle is accepted, giving back-to-back patterns
//   with one idle cycle). Next state IDLE, or SHIFT if load accepted.
//  en has no effect in IDLE/DONE (loads accepted with en=0; first bit waits for en).
//  Total enabled cycles per job = len*(repeat+1); done follows last bit by 1 cycle.
//  len=1 legal: single bit per pass. bit_idx/pass_cnt never wrap below 0.
// TESTING (drive overlapping_sequence_detector_0110 from data_out, en=data_valid)
//  T1 load 8'b0000_0110 len=4 rep=0, en=1 at N -> data_out 0,1,1,0 in N+1..N+4,
//     data_valid=1 those cycles, done=1 at N+5; detector detected=1 once.
//  T2 load 7'b0110110 len=7 rep=0 -> 7 bits, detector fires twice (overlap), done at N+8.
//  T3 load 4'b0110 len=4 rep=2 -> 12 contiguous bits 011001100110, 3 detections,
//     done at N+13, busy high N+1..N+12.
//  T4 same as T1 with en=0 for 2 cycles after 2nd bit -> data_valid=0, data_out
//     held at 1; stream resumes 1,0; done 2 cycles later (N+7).
//  T5 load_valid pulsed with 8'hFF mid-T1 -> ignored, stream unchanged; load at
//     done cycle accepted, next pattern starts next cycle.
//  T6 reset asserted after 2nd bit of T3 -> next cycle all outputs at reset values,
//     no done; len=0 load then sends all WIDTH bits.

Source files
------------

// File: rtl/serial_pattern_generator.sv
// Serializing transmitter: accepts a parallel pattern over a valid/ready load port
// and shifts it out MSB-first, optionally repeated, one bit per enabled clock.
module serial_pattern_generator #(
  parameter int   WIDTH      = 8,
  parameter int   REP_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [WIDTH-1:0]           load_pattern,
  input  logic [$clog2(WIDTH+1)-1:0] load_len,
  input  logic [REP_W-1:0]           load_repeat,
  output logic                       data_out,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = $clog2(WIDTH+1);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pattern_q, pattern_d;
  logic [IDX_W-1:0]  lenm1_q, lenm1_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [REP_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic              last_q, last_d;
  logic              data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              step;

  // Index of the pattern MSB; a zero or oversized length selects the full width.
  function automatic logic [IDX_W-1:0] eff_msb_idx(input logic [LEN_W-1:0] len);
    logic over;
    over = (len == '0) || (len > LEN_W'(WIDTH));
    return over ? IDX_W'(WIDTH - 1) : IDX_W'(len - LEN_W'(1));
  endfunction

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    lenm1_d      = lenm1_q;
    bit_idx_d    = bit_idx_q;
    pass_cnt_d   = pass_cnt_q;
    last_d       = last_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    step         = 1'b0;

    unique case (state_q)
      S_SHIFT: begin
        // last_q keeps busy high while the final bit is on the wire.
        if (last_q) begin
          state_d    = S_DONE;
          data_out_d = IDLE_LEVEL;
          last_d     = 1'b0;
        end else begin
          step = en;
        end
      end
      default: begin
        state_d    = S_IDLE;
        data_out_d = IDLE_LEVEL;
        if (load_valid) begin
          state_d    = S_SHIFT;
          pattern_d  = load_pattern;
          lenm1_d    = eff_msb_idx(load_len);
          bit_idx_d  = lenm1_d;
          pass_cnt_d = load_repeat;
          last_d     = 1'b0;
          // The capture edge already emits the MSB when enabled.
          step       = en;
        end
      end
    endcase

    if (step) begin
      data_out_d   = pattern_d[bit_idx_d];
      data_valid_d = 1'b1;
      if (bit_idx_d == '0) begin
        if (pass_cnt_d == '0) begin
          last_d = 1'b1;
        end else begin
          pass_cnt_d = pass_cnt_d - REP_W'(1);
          bit_idx_d  = lenm1_d;
        end
      end else begin
        bit_idx_d = bit_idx_d - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_idx_q    <= '0;
      pass_cnt_q   <= '0;
      last_q       <= 1'b0;
      data_out_q   <= IDLE_LEVEL;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      pass_cnt_q   <= pass_cnt_d;
      last_q       <= last_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
    pattern_q <= pattern_d;
    lenm1_q   <= lenm1_d;
  end

  assign load_ready = (state_q != S_SHIFT);
  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

`ifndef SYNTHESIS
  a_done_pulse: assert property (@(posedge clk) disable iff (reset) done |=> !done);
  a_valid_busy: assert property (@(posedge clk) disable iff (reset) data_valid |-> busy);
`endif

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Self-checking bench for serial_pattern_generator: vector table, corner-case
// sequences and randomized traffic against a bit-queue reference model.
module tb_serial_pattern_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_pattern = 8'h00;
  logic [3:0] load_len = 4'd0;
  logic [3:0] load_repeat = 4'd0;
  logic       data_out;
  logic       data_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  serial_pattern_generator #(.WIDTH(8), .REP_W(4), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_pattern(load_pattern), .load_len(load_len), .load_repeat(load_repeat),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: the job is a queue of bits still to be sent.
  bit   m_active = 1'b0;
  bit   m_done = 1'b0;
  bit   m_valid = 1'b0;
  logic m_out = 1'b0;
  bit   q[$];

  // Overlapping 0110 detector fed from the observed stream.
  logic [3:0] det_sr = 4'hF;
  int         det_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int L;
    if (reset) begin
      m_active = 0; m_done = 0; m_valid = 0; m_out = 1'b0;
      q.delete();
      return;
    end
    if (!m_active) begin
      m_done = 0; m_valid = 0; m_out = 1'b0;
      if (load_valid) begin
        L = (load_len == 0 || load_len > 8) ? 8 : int'(load_len);
        for (int p = 0; p <= int'(load_repeat); p++)
          for (int i = L - 1; i >= 0; i--) q.push_back(load_pattern[i]);
        m_active = 1;
        if (en) begin m_out = q.pop_front(); m_valid = 1; end
      end
    end else if (q.size() == 0) begin
      m_active = 0; m_done = 1; m_valid = 0; m_out = 1'b0;
    end else if (en) begin
      m_out = q.pop_front(); m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {load_ready, busy, done, data_valid, data_out},
        {!m_active, m_active, m_done, m_valid, m_out});
    if (data_valid === 1'b1) begin
      det_sr = {det_sr[2:0], data_out};
      if (det_sr == 4'b0110) det_cnt++;
    end
  endtask

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [3:0]  rep;
    logic [31:0] bits;
    int          n;
    int          det;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    det_sr = 4'hF; det_cnt = 0;
    load_pattern = v.pat; load_len = v.len; load_repeat = v.rep;
    load_valid = 1'b1; en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      if (k > 0) tick();
      chk($sformatf("v%0d bit%0d {valid,out,busy}", idx, k),
          {data_valid, data_out, busy}, {1'b1, v.bits[v.n-1-k], 1'b1});
    end
    tick();
    chk($sformatf("v%0d done cycle {done,busy,valid,out,ready}", idx),
        {done, busy, data_valid, data_out, load_ready}, 5'b10001);
    chk($sformatf("v%0d detections", idx), det_cnt, v.det);
    tick();
    chk($sformatf("v%0d idle after done", idx), {done, busy, load_ready}, 3'b001);
  endtask

  initial begin
    vecs[0] = '{8'b0000_0110, 4'd4, 4'd0, 32'b0110,         4,  1};
    vecs[1] = '{8'b0011_0110, 4'd7, 4'd0, 32'b0110110,      7,  2};
    vecs[2] = '{8'b0000_0110, 4'd4, 4'd2, 32'b011001100110, 12, 3};
    vecs[3] = '{8'hA5,        4'd0, 4'd0, 32'b10100101,     8,  0};
    vecs[4] = '{8'h01,        4'd1, 4'd3, 32'b1111,         4,  0};
    vecs[5] = '{8'hC3,        4'd9, 4'd0, 32'b11000011,     8,  0};
    vecs[6] = '{8'h02,        4'd2, 4'd1, 32'b1010,         4,  0};
    vecs[7] = '{8'h00,        4'd1, 4'd0, 32'b0,            1,  0};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("reset {ready,busy,done,valid,out}",
        {load_ready, busy, done, data_valid, data_out}, 5'b10000);
    reset = 1'b0;
    en = 1'b1;
    tick();
    chk("idle after reset", {load_ready, busy, done, data_valid}, 4'b1000);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // en=0 stall after the second bit
    load_pattern = 8'b0000_0110; load_len = 4'd4; load_repeat = 4'd0;
    load_valid = 1'b1; en = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("stall bit0", {data_valid, data_out}, 2'b10);
    tick();
    chk("stall bit1", {data_valid, data_out}, 2'b11);
    en = 1'b0;
    tick();
    chk("stall hold1", {data_valid, data_out, busy}, 3'b011);
    tick();
    chk("stall hold2", {data_valid, data_out, busy}, 3'b011);
    en = 1'b1;
    tick();
    chk("stall bit2", {data_valid, data_out}, 2'b11);
    tick();
    chk("stall bit3", {data_valid, data_out}, 2'b10);
    tick();
    chk("stall done", {done, data_valid, busy}, 3'b100);

    // Load ignored mid-stream; load in the done cycle accepted
    tick();
    load_valid = 1'b1;
    tick();
    chk("ignore bit0", {data_valid, data_out}, 2'b10);
    load_pattern = 8'hFF; load_len = 4'd8; load_repeat = 4'd3;
    tick();
    chk("ignore bit1", {data_valid, data_out, load_ready}, 3'b110);
    load_valid = 1'b0;
    tick();
    chk("ignore bit2", {data_valid, data_out}, 2'b11);
    tick();
    chk("ignore bit3", {data_valid, data_out}, 2'b10);
    tick();
    chk("b2b done", {done, load_ready}, 2'b11);
    load_pattern = 8'h0A; load_len = 4'd4; load_repeat = 4'd0; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("b2b first bit", {data_valid, data_out, busy, done}, 4'b1110);
    tick();
    chk("b2b bit1", {data_valid, data_out}, 2'b10);
    tick();
    tick();
    chk("b2b bit3", {data_valid, data_out}, 2'b10);
    tick();
    chk("b2b done2", {done, busy}, 2'b10);
    tick();

    // Reset aborts a job mid-stream
    load_pattern = 8'b0000_0110; load_len = 4'd4; load_repeat = 4'd2; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    chk("abort bit1", {data_valid, data_out}, 2'b11);
    reset = 1'b1;
    tick();
    chk("abort reset values", {load_ready, busy, done, data_valid, data_out}, 5'b10000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort no done %0d", i), {load_ready, busy, done, data_valid}, 4'b1000);
    end
    run_vec('{8'h96, 4'd0, 4'd0, 32'b10010110, 8, 1}, 8);

    // Load with en=0: first bit waits for en
    load_pattern = 8'h80; load_len = 4'd0; load_repeat = 4'd0; load_valid = 1'b1; en = 1'b0;
    tick();
    load_valid = 1'b0;
    chk("en0 load accepted", {busy, load_ready, data_valid}, 3'b100);
    tick();
    chk("en0 waiting", {busy, data_valid, data_out}, 3'b100);
    en = 1'b1;
    tick();
    chk("en0 first bit", {data_valid, data_out}, 2'b11);
    for (int i = 0; i < 10; i++) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 149) == 0);
      en           = ($urandom_range(0, 3) != 0);
      load_valid   = ($urandom_range(0, 3) == 0);
      load_pattern = 8'($urandom);
      load_len     = 4'($urandom_range(0, 15));
      load_repeat  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 2));
      tick();
    end
    reset = 1'b0; load_valid = 1'b0; en = 1'b1;
    for (int c = 0; c < 200; c++) tick();
    chk("final idle", {load_ready, busy, done, data_valid}, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
